in_trans: RTL and testbench
===========================

Name: in_trans

Overview:
- Host-side USB IN transaction controller, the read-direction counterpart of the OUT transaction FSM.
- On start from the read/write FSM, requests an IN token from the packet sender and waits for a DATA0 from the packet receiver.
- Returns ACK on clean data, or NAK on corrupt or absent data so the device resends.
- Delivers the captured payload plus done/success/failure back to the read/write FSM.

Parameters:
- DATA_W, 64: payload width captured from the receiver.
- TIMEOUT_CYCLES, 255: cycles in WAIT_DATA with no packet activity before a timeout is declared.
- MAX_ERRORS, 8: combined count of timeouts and corrupt packets that ends the transaction in failure.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  read/write FSM request; sampled only in IDLE.
- done  out  1  one-cycle pulse; transaction finished.
- success  out  1  one-cycle pulse with done; data_out valid.
- failure  out  1  one-cycle pulse with done; error limit reached.
- data_out  out  DATA_W  last successfully received payload.
- sent  in  1  packet sender finished the current packet (one-cycle pulse).
- send_IN  out  1  one-cycle request: send IN token.
- send_ACK  out  1  one-cycle request: send ACK handshake.
- send_NAK  out  1  one-cycle request: send NAK handshake.
- rec_start  in  1  receiver is mid-packet; level signal.
- rec_DATA0  in  1  one-cycle pulse: DATA0 packet complete.
- rec_error  in  1  one-cycle pulse: packet ended with CRC, PID or EOP error.
- rec_data  in  DATA_W  payload; valid in the rec_DATA0 cycle.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE; all pulse outputs 0.
  - data_out = 0; err_cnt = 0; timer = 0.
  - No partial handshake is completed after reset.
- All control outputs are Mealy and asserted in the cycle the transition condition holds. Each is a single-cycle pulse.
- IDLE:
  - start=1: send_IN=1, err_cnt cleared, go to WAIT_SEND_IN. Latency from start to send_IN is 0 cycles.
  - start=0: stay in IDLE.
- WAIT_SEND_IN: on sent, clear timer and go to WAIT_DATA.
- WAIT_DATA, priority order (highest first):
  1. rec_error: corrupt packet; apply the error rule below.
  2. rec_DATA0: data_out <= rec_data (updates next edge); send_ACK=1; go to WAIT_SEND_ACK.
  3. rec_start: timer held at 0, stay in WAIT_DATA.
  4. timer == TIMEOUT_CYCLES-1: timeout; apply the error rule below.
  5. Otherwise: timer++.
- Error rule (corrupt packet or timeout):
  - err_cnt == MAX_ERRORS-1: done=1, failure=1, no NAK sent, go to IDLE.
  - Otherwise: err_cnt++, send_NAK=1, go to WAIT_SEND_NAK.
- WAIT_SEND_NAK: on sent, clear timer and return to WAIT_DATA. The device resends; no new IN token is issued.
- WAIT_SEND_ACK: on sent, done=1, success=1, go to IDLE.
- data_out changes only on an accepted DATA0. It holds its value through failures and later transactions until the next success.
- start outside IDLE is ignored. rec_* outside WAIT_DATA is ignored.
- Widths:
  - timer is clog2(TIMEOUT_CYCLES+1) bits and never wraps, since it is cleared on exit.
  - err_cnt is clog2(MAX_ERRORS+1) bits.
- Timeout count: with no activity, send_NAK fires exactly TIMEOUT_CYCLES cycles after entering WAIT_DATA (entry cycle counts as timer=0).

Optional Feature:
- Macro IN_TRANS_ERR_CNT_EN.
- Defined: adds output port err_count (clog2(MAX_ERRORS+1) bits).
  - Reports err_cnt as registered.
  - Valid with done and held until the next start in IDLE.
  - Value on failure is MAX_ERRORS; reset value 0.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Package usb_trans_pkg:
  - state enum (IDLE, WAIT_SEND_IN, WAIT_DATA, WAIT_SEND_NAK, WAIT_SEND_ACK).
  - default TIMEOUT_CYCLES and MAX_ERRORS constants.
  - USB payload width constant.
  - Shared with the OUT transaction block.
- Sub-module trans_timer:
  - clear/hold/increment counter with a terminal-count flag at TIMEOUT_CYCLES-1.
  - Reusable by the OUT transaction block.

Test Plan:
- Clean read: start; sent after 5 cycles; rec_DATA0 with rec_data=64'hDEAD_BEEF_0123_4567 → send_ACK the same cycle; after sent, done&success; data_out=64'hDEAD_BEEF_0123_4567.
- Corrupt then good: rec_error at attempt 1 → send_NAK; after sent, rec_DATA0 → success; err_count=1 when IN_TRANS_ERR_CNT_EN is defined.
- Silent device: no rec_* at all → 7 send_NAK pulses each 255 cycles after WAIT_DATA entry; the 8th timeout gives done&failure with no NAK; data_out unchanged from the previous value.
- rec_start held 300 cycles, then rec_DATA0 → no timeout; success.
- Same cycle rec_error=1, rec_DATA0=1 → treated as error: send_NAK=1, send_ACK=0, data_out unchanged.
- reset_n low while in WAIT_SEND_ACK → immediately IDLE, all outputs 0, data_out=0; a subsequent start restarts cleanly with send_IN.

Source files
------------

// File: rtl/usb_trans_pkg.sv
// USB transaction package: FSM states and default sizing shared by
// the IN and OUT transaction controllers.
package usb_trans_pkg;

  localparam int USB_DATA_W         = 64;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int DEF_MAX_ERRORS     = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SEND_IN,
    WAIT_DATA,
    WAIT_SEND_NAK,
    WAIT_SEND_ACK
  } trans_state_t;

endpackage

// File: rtl/trans_timer.sv
// Clear/hold/increment timeout counter with terminal-count flag.
// Saturates at the terminal count; the owner clears it on exit.
module trans_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  assign tc = (count_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (inc && !tc)
      count_d = count_q + TW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/in_trans.sv
// Host-side USB IN transaction controller (IN token, DATA0, ACK/NAK).
// Define IN_TRANS_ERR_CNT_EN to expose the error count as err_count.
module in_trans
  import usb_trans_pkg::*;
#(
  parameter int DATA_W         = USB_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_ERRORS     = DEF_MAX_ERRORS
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              done,
  output logic              success,
  output logic              failure,
  output logic [DATA_W-1:0] data_out,
  input  logic              sent,
  output logic              send_IN,
  output logic              send_ACK,
  output logic              send_NAK,
  input  logic              rec_start,
  input  logic              rec_DATA0,
  input  logic              rec_error,
  input  logic [DATA_W-1:0] rec_data
`ifdef IN_TRANS_ERR_CNT_EN
  ,
  output logic [$clog2(MAX_ERRORS+1)-1:0] err_count
`endif
);

  localparam int EW = $clog2(MAX_ERRORS + 1);

  trans_state_t      state_q, state_d;
  logic [EW-1:0]     err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic tmr_clear, tmr_inc, tmr_tc;
  logic err_evt;
  logic in_c, ack_c, nak_c;
  logic done_c, ok_c, fail_c;

  // Activity on the bus keeps the timeout from running
  assign tmr_clear = (state_q != WAIT_DATA) || rec_start;
  assign tmr_inc   = (state_q == WAIT_DATA);

  trans_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (tmr_clear),
    .inc    (tmr_inc),
    .tc     (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    data_d  = data_q;
    err_evt = 1'b0;
    in_c    = 1'b0;
    ack_c   = 1'b0;
    nak_c   = 1'b0;
    done_c  = 1'b0;
    ok_c    = 1'b0;
    fail_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          in_c    = 1'b1;
          err_d   = '0;
          state_d = WAIT_SEND_IN;
        end
      end
      WAIT_SEND_IN: begin
        if (sent)
          state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (rec_error) begin
          err_evt = 1'b1;
        end else if (rec_DATA0) begin
          data_d  = rec_data;
          ack_c   = 1'b1;
          state_d = WAIT_SEND_ACK;
        end else if (!rec_start && tmr_tc) begin
          err_evt = 1'b1;
        end
      end
      WAIT_SEND_NAK: begin
        if (sent)
          state_d = WAIT_DATA;
      end
      WAIT_SEND_ACK: begin
        if (sent) begin
          done_c  = 1'b1;
          ok_c    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (err_evt) begin
      err_d = err_q + EW'(1);
      if (err_q == EW'(MAX_ERRORS - 1)) begin
        done_c  = 1'b1;
        fail_c  = 1'b1;
        state_d = IDLE;
      end else begin
        nak_c   = 1'b1;
        state_d = WAIT_SEND_NAK;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      err_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Mealy pulses are forced low while reset is held
  assign send_IN  = in_c & reset_n;
  assign send_ACK = ack_c & reset_n;
  assign send_NAK = nak_c & reset_n;
  assign done     = done_c & reset_n;
  assign success  = ok_c & reset_n;
  assign failure  = fail_c & reset_n;
  assign data_out = data_q;

`ifdef IN_TRANS_ERR_CNT_EN
  assign err_count = failure ? EW'(MAX_ERRORS) : err_q;
`endif

endmodule

// File: tb/tb_in_trans.sv
// Randomized scoreboard bench for in_trans against a transaction-level
// model of expected handshake pulses, completion and payload.
module tb_in_trans;

  localparam int T  = 255;
  localparam int ME = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, sent, rec_start, rec_DATA0, rec_error;
  logic [63:0] rec_data;
  logic        done, success, failure, send_IN, send_ACK, send_NAK;
  logic [63:0] data_out;
`ifdef IN_TRANS_ERR_CNT_EN
  logic [3:0]  err_count;
`endif

  in_trans dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .done     (done),
    .success  (success),
    .failure  (failure),
    .data_out (data_out),
    .sent     (sent),
    .send_IN  (send_IN),
    .send_ACK (send_ACK),
    .send_NAK (send_NAK),
    .rec_start(rec_start),
    .rec_DATA0(rec_DATA0),
    .rec_error(rec_error),
    .rec_data (rec_data)
`ifdef IN_TRANS_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clock = ~clock;

  localparam logic [5:0] EV_IN   = 6'b100000;
  localparam logic [5:0] EV_ACK  = 6'b010000;
  localparam logic [5:0] EV_NAK  = 6'b001000;
  localparam logic [5:0] EV_OK   = 6'b000110;
  localparam logic [5:0] EV_FAIL = 6'b000101;

  typedef struct {
    int          cyc;
    logic [5:0]  v;
    logic [63:0] data;
    int          ec;
  } ev_t;

  ev_t         q[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  int          errs;
  logic [63:0] model_data;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
                  nm, act, req, cyc);
  endtask

  task automatic expect_ev(input logic [5:0] v);
    ev_t e;
    e.cyc  = cyc;
    e.v    = v;
    e.data = model_data;
    e.ec   = (v == EV_FAIL) ? ME : errs;
    q.push_back(e);
  endtask

  // Monitor: compares every DUT pulse against the scoreboard
  ev_t        m_e;
  logic [5:0] m_v;
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      m_v = {send_IN, send_ACK, send_NAK, done, success, failure};
      while (q.size() > 0 && q[0].cyc < cyc) begin
        m_e = q.pop_front();
        check("missed_event", 64'(0), 64'(m_e.v));
      end
      if (m_v != 6'b0) begin
        if (q.size() == 0) begin
          check("unexpected_event", 64'(m_v), 64'(0));
        end else begin
          m_e = q.pop_front();
          check("event_kind", 64'(m_v), 64'(m_e.v));
          check("event_cycle", 64'(cyc), 64'(m_e.cyc));
          if (done) begin
            check("data_out_at_done", data_out, m_e.data);
`ifdef IN_TRANS_ERR_CNT_EN
            check("err_count_at_done", 64'(err_count), 64'(m_e.ec));
`endif
          end
        end
      end
    end
  end

  task automatic drive(input bit st, input bit sn, input bit rs,
                       input bit d0, input bit er, input logic [63:0] dat);
    start     = st;
    sent      = sn;
    rec_start = rs;
    rec_DATA0 = d0;
    rec_error = er;
    rec_data  = dat;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 64'(0));
  endtask

  // Stray start/rec_* while waiting on the sender must be ignored
  task automatic wait_sent(input int k);
    repeat (k)
      drive(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom});
  endtask

  task automatic error_event(output bit fin);
    if (errs == ME - 1) begin
      expect_ev(EV_FAIL);
      fin = 1;
    end else begin
      errs++;
      expect_ev(EV_NAK);
      fin = 0;
    end
  endtask

  // kind: 0 data, 1 error, 2 timeout, 3 error+data, 4 long rec_start
  task automatic attempt(input int kind, input int d, input logic [63:0] dat,
                         output bit fin);
    fin = 0;
    unique case (kind)
      0, 4: begin
        if (kind == 4) repeat (d) drive(0, 0, 1, 0, 0, 64'(0));
        else idle(d);
        expect_ev(EV_ACK);
        drive(0, 0, 0, 1, 0, dat);
        model_data = dat;
        wait_sent($urandom_range(0, 6));
        expect_ev(EV_OK);
        drive(0, 1, 0, 0, 0, 64'(0));
        fin = 1;
      end
      1: begin
        idle(d);
        error_event(fin);
        drive(0, 0, 0, 0, 1, 64'(0));
      end
      2: begin
        idle(T - 1);
        error_event(fin);
        drive(0, 0, 0, 0, 0, 64'(0));
      end
      default: begin
        idle(d);
        error_event(fin);
        drive(0, 0, 0, 1, 1, dat);
      end
    endcase
    if (!fin) begin
      wait_sent($urandom_range(0, 6));
      drive(0, 1, 0, 0, 0, 64'(0));
    end
  endtask

  int pk[$];
  int pd[$];

  task automatic trans(input int sent_delay);
    bit fin;
    int k, d;
    errs = 0;
    expect_ev(EV_IN);
    drive(1, 0, 0, 0, 0, 64'(0));
    wait_sent(sent_delay);
    drive(0, 1, 0, 0, 0, 64'(0));
    fin = 0;
    while (!fin) begin
      if (pk.size() > 0) begin
        k = pk.pop_front();
        d = pd.pop_front();
      end else begin
        k = $urandom_range(0, 19);
        k = (k < 4) ? 0 : (k < 11) ? 1 : (k < 13) ? 2 :
            (k < 17) ? 3 : 4;
        d = (k == 4) ? $urandom_range(1, 300) : $urandom_range(0, 20);
      end
      attempt(k, d, {$urandom, $urandom}, fin);
    end
    idle($urandom_range(1, 4));
  endtask

  initial begin
    reset_n    = 1'b0;
    model_data = '0;
    errs       = 0;
    drive(1, 1, 1, 1, 1, '1);
    check("reset_send_IN", 64'(send_IN), 64'(0));
    check("reset_pulses", 64'({send_ACK, send_NAK, done, success, failure}),
          64'(0));
    check("reset_data_out", data_out, 64'(0));
    start = 0; sent = 0; rec_start = 0; rec_DATA0 = 0; rec_error = 0;
    #2 reset_n = 1'b1;
    idle(2);

    // clean read
    pk = '{0}; pd = '{3};
    begin
      bit fin;
      errs = 0;
      expect_ev(EV_IN);
      drive(1, 0, 0, 0, 0, 64'(0));
      idle(4);
      drive(0, 1, 0, 0, 0, 64'(0));
      void'(pk.pop_front()); void'(pd.pop_front());
      attempt(0, 3, 64'hDEAD_BEEF_0123_4567, fin);
      idle(1);
      check("clean_read_data", data_out, 64'hDEAD_BEEF_0123_4567);
    end

    // corrupt then good
    pk = '{1, 0}; pd = '{2, 5};
    trans(2);

    // silent device: eight timeouts, then failure
    pk = '{2, 2, 2, 2, 2, 2, 2, 2}; pd = '{0, 0, 0, 0, 0, 0, 0, 0};
    trans(1);
    check("data_held_after_fail", data_out, model_data);

    // long bus activity never times out
    pk = '{4}; pd = '{300};
    trans(0);

    // error and DATA0 together count as error
    pk = '{3, 0}; pd = '{1, 1};
    trans(3);

    // reset while waiting for the ACK to go out
    begin
      errs = 0;
      expect_ev(EV_IN);
      drive(1, 0, 0, 0, 0, 64'(0));
      drive(0, 1, 0, 0, 0, 64'(0));
      expect_ev(EV_ACK);
      drive(0, 0, 0, 1, 0, 64'h0123_4567_89AB_CDEF);
      drive(0, 0, 0, 0, 0, 64'(0));
      sent = 1'b1;
      start = 1'b1;
      reset_n = 1'b0;
      #1;
      check("rst_ack_pulses",
            64'({send_IN, send_ACK, send_NAK, done, success, failure}),
            64'(0));
      check("rst_ack_data_out", data_out, 64'(0));
      model_data = '0;
      @(posedge clock);
      #2;
      start = 1'b0;
      sent = 1'b0;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      pk = '{0}; pd = '{0};
      trans(1);
    end

    repeat (20) trans($urandom_range(0, 8));

    idle(3);
    check("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
